// File: rtl/parser_record_fifo.sv
// parser_record_fifo: elastic record buffer between the packet parser and its
// consumer. Records enter on dataIn/dataIn_val/dataIn_ready and leave
// first-word-fall-through on dataOut/dataOut_val/dataOut_ready.
// The optional statistics counters (lostCount, recCount, statsClear) are
// built only when the macro PARSER_FIFO_STATS_EN is defined.
module parser_record_fifo #(
  parameter int DATA_W = 296,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic [0:DATA_W-1] dataIn,
  input  logic              dataIn_val,
  output logic              dataIn_ready,
  input  logic              packetLost,
  output logic [0:DATA_W-1] dataOut,
  output logic              dataOut_val,
  input  logic              dataOut_ready
`ifdef PARSER_FIFO_STATS_EN
  ,
  output logic [CNT_W-1:0]  lostCount,
  output logic [CNT_W-1:0]  recCount,
  input  logic              statsClear
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  // Record storage; deliberately not reset so it maps onto plain RAM.
  logic [0:DATA_W-1] mem [DEPTH];

  logic [PTR_W-1:0] wrPtrReg;
  logic [PTR_W-1:0] rdPtrReg;
  logic [PTR_W:0]   countReg;
  logic [PTR_W:0]   countNext;
  logic             readyReg;
  logic             pushEn;
  logic             popEn;

  // The producer only ever sees the registered ready, so a full FIFO refuses
  // a push in the same cycle a pop frees a slot.
  assign pushEn       = dataIn_val && readyReg;
  assign popEn        = dataOut_val && dataOut_ready;
  assign dataIn_ready = readyReg;
  assign dataOut_val  = (countReg != '0);
  // Head record is shown only while valid, so reset and empty both give zero.
  assign dataOut      = dataOut_val ? mem[rdPtrReg] : '0;

  // Occupancy update from the push/pop pair.
  always_comb begin
    countNext = countReg;
    case ({pushEn, popEn})
      2'b10:   countNext = countReg + 1'b1;
      2'b01:   countNext = countReg - 1'b1;
      default: countNext = countReg;
    endcase
  end

  // Pointer, occupancy and ready registers; ready comes up at the first edge
  // after reset release.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
      readyReg <= 1'b0;
    end else begin
      if (pushEn) wrPtrReg <= wrPtrReg + 1'b1;
      if (popEn)  rdPtrReg <= rdPtrReg + 1'b1;
      countReg <= countNext;
      readyReg <= (countNext != FULL_CNT);
    end
  end

  // Record write into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (pushEn) mem[wrPtrReg] <= dataIn;
  end

`ifdef PARSER_FIFO_STATS_EN
  logic [CNT_W-1:0] lostReg;
  logic [CNT_W-1:0] recReg;

  assign lostCount = lostReg;
  assign recCount  = recReg;

  // Saturating statistics counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      lostReg <= '0;
      recReg  <= '0;
    end else if (statsClear) begin
      lostReg <= '0;
      recReg  <= '0;
    end else begin
      if (packetLost && (lostReg != '1)) lostReg <= lostReg + 1'b1;
      if (popEn && (recReg != '1))       recReg  <= recReg + 1'b1;
    end
  end
`else
  // Loss pulses are accepted but have no effect without statistics.
  logic unusedPacketLost;
  assign unusedPacketLost = packetLost;
`endif

endmodule
